// File: rtl/ha_array_accum_ctrl.sv
// Sequencing controller for the 8x8 approximate-multiplier HA array: latches an operand pair,
// sums the four array rows one per clock into a product and holds it until the consumer takes it.
module ha_array_accum_ctrl #(
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [7:0]       arr_x,
  output logic [7:0]       arr_y,
  input  logic [6:0]       arr0_b,
  input  logic [8:0]       arr0_t,
  input  logic [6:0]       arr1_b,
  input  logic [8:0]       arr1_t,
  input  logic [6:0]       arr2_b,
  input  logic [8:0]       arr2_t,
  input  logic [6:0]       arr3_b,
  input  logic [8:0]       arr3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [7:0]         arr_x_q, arr_x_d, arr_y_q, arr_y_d;
  logic [OUT_W-1:0]   acc_q, acc_d, out_p_q, out_p_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  logic [8:0]         row_t;
  logic [6:0]         row_b;
  logic [4:0]         row_sh;
  logic [OUT_W-1:0]   row_val, row_sum;

  // Row i sits at base weight 2i; the carry vector is two bits above the sum vector.
  always_comb begin
    row_t = arr0_t;
    row_b = arr0_b;
    case (row_idx_q)
      2'd1: begin row_t = arr1_t; row_b = arr1_b; end
      2'd2: begin row_t = arr2_t; row_b = arr2_b; end
      2'd3: begin row_t = arr3_t; row_b = arr3_b; end
      default: begin row_t = arr0_t; row_b = arr0_b; end
    endcase
    row_sh  = {2'b00, row_idx_q, 1'b0};
    row_val = (OUT_W'(row_t) << row_sh) + (OUT_W'(row_b) << (row_sh + 5'd2));
    row_sum = acc_q + row_val;
  end

  always_comb begin
    state_d     = state_q;
    arr_x_d     = arr_x_q;
    arr_y_d     = arr_y_q;
    acc_d       = acc_q;
    row_idx_d   = row_idx_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          arr_x_d   = in_x;
          arr_y_d   = in_y;
          acc_d     = '0;
          row_idx_d = 2'd0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (row_idx_q == 2'd3) begin
          out_p_d     = row_sum;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          acc_d     = row_sum;
          row_idx_d = row_idx_q + 2'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (op_count_q != {CNT_W{1'b1}}) op_count_d = op_count_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      arr_x_q     <= '0;
      arr_y_q     <= '0;
      acc_q       <= '0;
      row_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      arr_x_q     <= arr_x_d;
      arr_y_q     <= arr_y_d;
      acc_q       <= acc_d;
      row_idx_q   <= row_idx_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign arr_x     = arr_x_q;
  assign arr_y     = arr_y_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_ha_array_accum_ctrl.sv
// Directed and random checks of the HA-array accumulation controller; rows are driven by the bench.
module tb_ha_array_accum_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [7:0]    in_x = '0, in_y = '0, arr_x, arr_y;
  logic [6:0]    arr0_b = '0, arr1_b = '0, arr2_b = '0, arr3_b = '0;
  logic [8:0]    arr0_t = '0, arr1_t = '0, arr2_t = '0, arr3_t = '0;
  logic          out_valid, out_ready = 1'b0, busy;
  logic [15:0]   out_p;
  logic [CW-1:0] op_count;

  int total = 0;
  int bad   = 0;
  int ops   = 0;

  ha_array_accum_ctrl #(.OUT_W(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .arr_x(arr_x), .arr_y(arr_y),
    .arr0_b(arr0_b), .arr0_t(arr0_t), .arr1_b(arr1_b), .arr1_t(arr1_t),
    .arr2_b(arr2_b), .arr2_t(arr2_t), .arr3_b(arr3_b), .arr3_t(arr3_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       x;
    logic [7:0]       y;
    logic [3:0][8:0]  t;
    logic [3:0][6:0]  b;
    logic [15:0]      p;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rows(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    arr0_t = t[0]; arr1_t = t[1]; arr2_t = t[2]; arr3_t = t[3];
    arr0_b = b[0]; arr1_b = b[1]; arr2_b = b[2]; arr3_b = b[3];
  endtask

  // Accepts one operand pair, checks latency and product, optionally stalls, then completes.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp_p,
                        input int stall);
    int lat;
    logic [15:0] held;
    in_x = x; in_y = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_in_ready", in_ready, 1'b0);
    chk("arr_x", arr_x, x);
    chk("arr_y", arr_y, y);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("out_p", out_p, exp_p);
    held = out_p;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_x = ~x; in_y = ~y;
      @(posedge clk); #1;
      chk("stall_out_p", out_p, held);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_arr_x", arr_x, x);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ops++;
    chk("done_valid", out_valid, 1'b0);
    chk("done_in_ready", in_ready, 1'b1);
    chk("op_count", op_count, (ops > 15) ? 15 : ops);
    chk("retain_arr_y", arr_y, y);
  endtask

  function automatic logic [15:0] model(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += (int'(t[i]) << (2 * i)) + (int'(b[i]) << (2 * i + 2));
    return 16'(s);
  endfunction

  initial begin
    vecs[0] = '{x: 8'd0,   y: 8'd255, t: '0, b: '0, p: 16'd0};
    vecs[1] = '{x: 8'd255, y: 8'd0,   t: '0, b: '0, p: 16'd0};
    vecs[2] = '{x: 8'd1,   y: 8'd1,   t: {9'd0, 9'd0, 9'd0, 9'd1}, b: '0, p: 16'd1};
    vecs[3] = '{x: 8'd3,   y: 8'd3,   t: {9'd0, 9'd0, 9'd0, 9'd5}, b: '0, p: 16'd5};
    vecs[4] = '{x: 8'h11,  y: 8'h22,  t: {9'h1FF, 9'd0, 9'd0, 9'd0},
                b: {7'h7F, 7'd0, 7'd0, 7'd0}, p: 16'hFEC0};
    vecs[5] = '{x: 8'h5A,  y: 8'hA5,  t: {9'd0, 9'd1, 9'd2, 9'd3},
                b: {7'd2, 7'd0, 7'd1, 7'd1}, p: 16'd559};
    vecs[6] = '{x: 8'hFF,  y: 8'hFF,  t: {4{9'h1FF}}, b: {4{7'h7F}}, p: 16'd21079};
    vecs[7] = '{x: 8'h0F,  y: 8'hF0,  t: {9'd0, 9'h1FF, 9'h1FF, 9'd0},
                b: {7'd0, 7'h7F, 7'h7F, 7'd0}, p: 16'd20380};

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_p", out_p, 16'd0);
    chk("rst_arr_x", arr_x, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-accumulation discards everything immediately.
    set_rows(vecs[6].t, vecs[6].b);
    in_x = 8'h77; in_y = 8'h66; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_arr_x", arr_x, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_output", out_valid, 1'b0);
    end

    // out_ready with no product pending must not count.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_ready", op_count, 0);

    for (int i = 0; i < 8; i++) begin
      set_rows(vecs[i].t, vecs[i].b);
      run_op(vecs[i].x, vecs[i].y, vecs[i].p, 0);
    end

    set_rows(vecs[5].t, vecs[5].b);
    run_op(8'hC3, 8'h3C, 16'd559, 10);

    for (int n = 0; n < 40; n++) begin
      logic [3:0][8:0] t;
      logic [3:0][6:0] b;
      for (int i = 0; i < 4; i++) begin
        t[i] = 9'($urandom);
        b[i] = 7'($urandom);
      end
      set_rows(t, b);
      run_op(8'($urandom), 8'($urandom), model(t, b), (n % 5 == 0) ? 3 : 0);
    end
    chk("op_count_sat", op_count, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
